// File: rtl/fifo_pixel_unpacker.sv
// fifo_pixel_unpacker: pops 32-bit words from a non-FWFT FIFO and re-packs the
// byte stream into 24-bit pixels (B oldest, then G, then R), with frame
// tracking via out_last / frame_done.
// Optional feature: define UNPACK_GRAY_EN to replace the pixel with a
// grey value floor((R+G+B)/3) replicated on all three channels.
module fifo_pixel_unpacker #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_empty,
    output logic        in_rd_en,
    input  logic [31:0] in_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_pixel,
    output logic        out_last,
    output logic        frame_done
);

    localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_TOTAL - 1);

    // Byte buffer: byte 0 (bits 7:0) is the oldest byte in the stream.
    logic [47:0]      byte_buf;
    logic [47:0]      buf_next;
    logic [2:0]       byte_cnt;
    logic [2:0]       cnt_after;
    logic [2:0]       cnt_next;
    logic             in_flight;
    logic [CNT_W-1:0] pixel_cnt;
    logic             accept;
    logic             last_accept;
    logic [7:0]       b_ch;
    logic [7:0]       g_ch;
    logic [7:0]       r_ch;

    assign out_valid   = (byte_cnt >= 3'd3);
    assign accept      = out_valid && out_ready;
    assign out_last    = out_valid && (pixel_cnt == LAST_IDX);
    assign last_accept = accept && out_last;

    assign b_ch = byte_buf[7:0];
    assign g_ch = byte_buf[15:8];
    assign r_ch = byte_buf[23:16];

    // Read request: only one read outstanding, room for a full word after this
    // cycle's consumption, and never in the cycle that closes a frame.
    always_comb begin
        cnt_after = accept ? (byte_cnt - 3'd3) : byte_cnt;
        in_rd_en  = reset && !in_empty && !in_flight && (cnt_after <= 3'd2) && !last_accept;
    end

    // Next buffer contents: drop the consumed pixel, then append a landing word
    // directly after the residual bytes; a frame end flushes everything.
    always_comb begin
        buf_next = accept ? {24'd0, byte_buf[47:24]} : byte_buf;
        cnt_next = cnt_after;
        if (in_flight) begin
            case (cnt_after)
                3'd0: begin
                    buf_next[31:0] = in_dout;
                    cnt_next       = 3'd4;
                end
                3'd1: begin
                    buf_next[39:8] = in_dout;
                    cnt_next       = 3'd5;
                end
                3'd2: begin
                    buf_next[47:16] = in_dout;
                    cnt_next        = 3'd6;
                end
                default: begin
                    cnt_next = cnt_after;
                end
            endcase
        end
        if (last_accept) begin
            buf_next = '0;
            cnt_next = '0;
        end
    end

`ifdef UNPACK_GRAY_EN
    logic [9:0] chan_sum;
    logic [7:0] gray;

    // Grey conversion: 10-bit sum keeps 3*255 exact before dividing by 3.
    always_comb begin
        chan_sum  = {2'b00, r_ch} + {2'b00, g_ch} + {2'b00, b_ch};
        gray      = 8'(chan_sum / 10'd3);
        out_pixel = out_valid ? {gray, gray, gray} : 24'd0;
    end
`else
    // Raw pixel output, forced to zero whenever no pixel is presented.
    always_comb begin
        out_pixel = out_valid ? {r_ch, g_ch, b_ch} : 24'd0;
    end
`endif

    // State registers: buffer, read-in-flight flag, pixel counter and frame pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_buf   <= '0;
            byte_cnt   <= '0;
            in_flight  <= 1'b0;
            pixel_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            byte_buf   <= buf_next;
            byte_cnt   <= cnt_next;
            in_flight  <= in_rd_en;
            frame_done <= last_accept;
            if (accept) begin
                pixel_cnt <= last_accept ? '0 : (pixel_cnt + 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// tb_fifo_pixel_unpacker: scoreboard bench for fifo_pixel_unpacker with a
// small frame (4x1). Follows UNPACK_GRAY_EN for the expected pixel values.
module tb_fifo_pixel_unpacker;

    localparam int W   = 4;
    localparam int H   = 1;
    localparam int PIX = W * H;

    logic        clk;
    logic        reset;
    logic        in_empty;
    logic        in_rd_en;
    logic [31:0] in_dout;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_pixel;
    logic        out_last;
    logic        frame_done;

    fifo_pixel_unpacker #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_empty   (in_empty),
        .in_rd_en   (in_rd_en),
        .in_dout    (in_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    int err_cnt = 0;
    int check_cnt = 0;

    logic [31:0] fifo_q[$];
    logic [7:0]  byte_q[$];
    logic [23:0] exp_q[$];
    bit          exp_last_q[$];
    int          model_idx = 0;

    logic [31:0] pending_word = 32'h0;
    bit          pending = 0;
    bit          fd_pending = 0;
    bit          ready_rand = 0;
    bit          ready_level = 0;
    int          cycle = 0;
    int          first_rd_cyc = -1;
    int          first_valid_cyc = -1;
    int          pop_cnt = 0;
    int          fd_count = 0;
    int          last_count = 0;
    int          accepted = 0;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stream stalls forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    function automatic logic [23:0] model_pixel(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
`ifdef UNPACK_GRAY_EN
        int         s;
        logic [7:0] y;
        s = int'(b) + int'(g) + int'(r);
        y = 8'(s / 3);
        return {y, y, y};
`else
        return {r, g, b};
`endif
    endfunction

    task automatic applyStimulus(input logic [31:0] word);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        fifo_q.push_back(word);
        for (int i = 0; i < 4; i++) begin
            byte_q.push_back(word[8*i +: 8]);
        end
        while (byte_q.size() >= 3) begin
            b0 = byte_q.pop_front();
            b1 = byte_q.pop_front();
            b2 = byte_q.pop_front();
            exp_q.push_back(model_pixel(b0, b1, b2));
            exp_last_q.push_back(model_idx == PIX - 1);
            model_idx = (model_idx + 1) % PIX;
        end
    endtask

    task automatic tick();
        bit was_last;
        @(negedge clk);
        cycle++;
        in_dout   = pending ? pending_word : 32'h0;
        in_empty  = (fifo_q.size() == 0);
        out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_level;
        #1;
        if (fd_pending || frame_done) begin
            checkOutput("frame_done", frame_done, fd_pending);
        end
        if (frame_done) fd_count++;
        fd_pending = 0;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cycle;
        if (out_valid) begin
            checkOutput("sb_has_pixel", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                if (out_ready) checkOutput("pixel", out_pixel, exp_q[0]);
                else           checkOutput("hold_pixel", out_pixel, exp_q[0]);
                checkOutput("last", out_last, exp_last_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    was_last = exp_last_q.pop_front();
                    fd_pending = was_last;
                    accepted++;
                    if (out_last) last_count++;
                end
            end
        end
        if (in_rd_en) begin
            checkOutput("rd_when_empty", in_empty, 0);
            checkOutput("rd_in_flight", pending, 0);
            if (first_rd_cyc < 0) first_rd_cyc = cycle;
            pop_cnt++;
            if (fifo_q.size() > 0) pending_word = fifo_q.pop_front();
            pending = 1;
        end else begin
            pending = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain_done", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_rd_en"}, in_rd_en, 0);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_pixel"}, out_pixel, 0);
        checkOutput({tag, "_last"}, out_last, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Main sequence of scenarios.
    initial begin
        reset     = 1'b0;
        in_empty  = 1'b1;
        out_ready = 1'b0;
        in_dout   = 32'h0;
        #1;
        in_empty = 1'b0;
        #1;
        check_reset_outputs("por");
        in_empty = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        $display("[TB] pack and latency");
        ready_level = 1;
        ready_rand  = 0;
        first_rd_cyc = -1;
        first_valid_cyc = -1;
        applyStimulus(32'h44332211);
        applyStimulus(32'h88776655);
        applyStimulus(32'hCCBBAA99);
        drain(100);
        checkOutput("latency", first_valid_cyc - first_rd_cyc, 2);

        $display("[TB] backpressure");
        ready_level = 0;
        repeat (2) begin
            applyStimulus(32'h44332211);
            applyStimulus(32'h88776655);
            applyStimulus(32'hCCBBAA99);
        end
        pop_cnt = 0;
        repeat (20) tick();
        checkOutput("bp_pops_le2", pop_cnt <= 2, 1);
        checkOutput("bp_valid", out_valid, 1);
        ready_level = 1;
        drain(200);

        $display("[TB] empty source");
        applyStimulus(32'h03020100);
        applyStimulus(32'h07060504);
        repeat (50) tick();
        checkOutput("starved_valid", out_valid, 0);
        checkOutput("starved_sb", exp_q.size(), 0);
        applyStimulus(32'h0B0A0908);
        drain(100);

        $display("[TB] frame boundaries");
        fd_count   = 0;
        last_count = 0;
        ready_rand = 1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(32'h10203040 + 32'h01010101 * i);
        end
        drain(400);
        checkOutput("frame_done_pulses", fd_count, 2);
        checkOutput("last_pixels", last_count, 2);

        $display("[TB] mid-frame reset");
        ready_rand  = 0;
        ready_level = 1;
        accepted    = 0;
        applyStimulus(32'hA1A2A3A4);
        applyStimulus(32'hB1B2B3B4);
        applyStimulus(32'hC1C2C3C4);
        for (int n = 0; n < 50 && accepted < 2; n++) tick();
        checkOutput("pixels_before_reset", accepted, 2);
        checkOutput("read_in_flight", pending, 1);
        @(negedge clk);
        in_dout = pending_word;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        in_empty = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("hold");
        fifo_q.delete();
        byte_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        model_idx  = 0;
        pending    = 0;
        fd_pending = 0;
        in_empty   = 1'b1;
        reset      = 1'b1;
        applyStimulus(32'h44332211);
        applyStimulus(32'h88776655);
        applyStimulus(32'hCCBBAA99);
        drain(100);

        $display("[TB] grey-range data");
        applyStimulus(32'hFF906030);
        applyStimulus(32'hFFFFFFFF);
        applyStimulus(32'hFFFFFFFF);
        drain(100);

        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
